// File: rtl/tnn_acc_pkg.sv
// rtl/tnn_acc_pkg.sv - shared FSM encoding and saturation bound helpers for the requant datapath
package tnn_acc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } fsm_t;

    localparam int SAT_W = 128;
    typedef logic signed [SAT_W-1:0] sat_t;

    function automatic sat_t sat_hi(input int w);
        return (sat_t'(1) <<< (w - 1)) - sat_t'(1);
    endfunction

    function automatic sat_t sat_lo(input int w);
        return -(sat_t'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/scale_requant_if.sv
// rtl/scale_requant_if.sv - accumulator input stream and requantized output stream bundle
interface scale_requant_if #(
    parameter int FEATURE_WIDTH = 32,
    parameter int OUT_WIDTH     = 8
);
    logic                            acc_valid;
    logic                            acc_ready;
    logic signed [FEATURE_WIDTH-1:0] acc_data;
    logic                            acc_last;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [OUT_WIDTH-1:0]     out_data;
    logic                            out_last;

    modport master (
        output acc_valid, acc_data, acc_last, out_ready,
        input  acc_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  acc_valid, acc_data, acc_last, out_ready,
        output acc_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - combinational shift/round/saturate of a fixed-point product
// SCALE_ROUND_EN: round half up before the shift; otherwise truncate toward -inf.
module requant_sat
    import tnn_acc_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 8,
    parameter int FRAC_BITS = 16
) (
    input  logic signed [IN_WIDTH-1:0]  prod_i,
    output logic signed [OUT_WIDTH-1:0] res_o,
    output logic                        sat_o
);
    // One guard bit so the rounding add cannot wrap the largest product.
    localparam int EXT_W = IN_WIDTH + 1;

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shifted;
    sat_t                    wide;

`ifdef SCALE_ROUND_EN
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (FRAC_BITS - 1);
    assign ext = $signed({prod_i[IN_WIDTH-1], prod_i}) + HALF;
`else
    assign ext = $signed({prod_i[IN_WIDTH-1], prod_i});
`endif

    assign shifted = ext >>> FRAC_BITS;
    assign wide    = sat_t'(shifted);

    always_comb begin
        res_o = shifted[OUT_WIDTH-1:0];
        sat_o = 1'b0;
        if (wide > sat_hi(OUT_WIDTH)) begin
            res_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat_o = 1'b1;
        end else if (wide < sat_lo(OUT_WIDTH)) begin
            res_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat_o = 1'b1;
        end
    end
endmodule

// File: rtl/scale_requant.sv
// rtl/scale_requant.sv - layer FSM plus two-stage multiply/requantize pipeline
// SCALE_ROUND_EN (in requant_sat) selects round-half-up instead of truncation.
module scale_requant
    import tnn_acc_pkg::*;
#(
    parameter int FEATURE_WIDTH = 32,
    parameter int OUT_WIDTH     = 8,
    parameter int FRAC_BITS     = 16,
    parameter int SCALER_LAT    = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            state,
    input  logic signed [FEATURE_WIDTH-1:0] scaler_in,
    scale_requant_if.slave                  bus,
    output logic                            done,
    output logic                            sat_flag
);
    localparam int PROD_W = 2 * FEATURE_WIDTH;
    localparam int CNT_W  = $clog2(SCALER_LAT + 2);

    fsm_t                            fsm_q, fsm_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic signed [FEATURE_WIDTH-1:0] scale_q, scale_d;
    logic                            s1_valid_q, s1_valid_d;
    logic                            s1_last_q, s1_last_d;
    logic signed [PROD_W-1:0]        s1_prod_q, s1_prod_d;
    logic                            out_valid_q, out_valid_d;
    logic                            out_last_q, out_last_d;
    logic signed [OUT_WIDTH-1:0]     out_data_q, out_data_d;
    logic                            sat_flag_q, sat_flag_d;

    logic                            s2_adv, s1_adv, acc_ready_w, acc_fire, out_fire, done_w;
    logic signed [OUT_WIDTH-1:0]     rq_data;
    logic                            rq_sat;

    requant_sat #(
        .IN_WIDTH (PROD_W),
        .OUT_WIDTH(OUT_WIDTH),
        .FRAC_BITS(FRAC_BITS)
    ) u_requant_sat (
        .prod_i(s1_prod_q),
        .res_o (rq_data),
        .sat_o (rq_sat)
    );

    assign s2_adv      = !out_valid_q || bus.out_ready;
    assign s1_adv      = !s1_valid_q || s2_adv;
    assign acc_ready_w = state && (fsm_q == RUN) && s1_adv;
    assign acc_fire    = bus.acc_valid && acc_ready_w;
    assign out_fire    = out_valid_q && bus.out_ready;

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        scale_d     = scale_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_prod_d   = s1_prod_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        sat_flag_d  = sat_flag_q;
        done_w      = 1'b0;

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = rq_data;
                out_last_d = s1_last_q;
                if (rq_sat) begin
                    sat_flag_d = 1'b1;
                end
            end
        end
        if (s1_adv) begin
            s1_valid_d = acc_fire;
            if (acc_fire) begin
                s1_prod_d = PROD_W'(bus.acc_data) * PROD_W'(scale_q);
                s1_last_d = bus.acc_last;
            end
        end

        case (fsm_q)
            IDLE: begin
                if (state) begin
                    fsm_d      = LOAD;
                    cnt_d      = '0;
                    sat_flag_d = 1'b0;
                end
            end
            LOAD: begin
                // scaler_in is only trustworthy on the final count.
                if (cnt_q == CNT_W'(SCALER_LAT)) begin
                    scale_d = scaler_in;
                    fsm_d   = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (acc_fire && bus.acc_last) begin
                    fsm_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_last_q) begin
                    fsm_d  = DONE;
                    done_w = 1'b1;
                end
            end
            DONE:    ;
            default: fsm_d = IDLE;
        endcase

        // Layer abort: everything in flight belongs to the dead layer.
        if (!state && (fsm_q != IDLE)) begin
            fsm_d       = IDLE;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            sat_flag_d  = 1'b0;
            done_w      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            scale_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            scale_q     <= scale_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign bus.acc_ready = acc_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign done          = done_w;
    assign sat_flag      = sat_flag_q;
endmodule

// File: tb/tb_scale_requant.sv
// tb/tb_scale_requant.sv - scoreboard bench for scale_requant (honours SCALE_ROUND_EN)
module tb_scale_requant;

    typedef struct {
        logic signed [7:0] data;
        logic              last;
        int                acc_cyc;
        bit                lat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               state = 1'b0;
    logic signed [31:0] scaler_in = '0;
    logic               done;
    logic               sat_flag;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    scale_requant_if #(.FEATURE_WIDTH(32), .OUT_WIDTH(8)) bus ();

    scale_requant #(
        .FEATURE_WIDTH(32),
        .OUT_WIDTH    (8),
        .FRAC_BITS    (16),
        .SCALER_LAT   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state),
        .scaler_in(scaler_in),
        .bus      (bus.slave),
        .done     (done),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint ev);
        checks++;
        if (act != ev) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, ev);
        end
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    initial begin : monitor
        exp_t              e;
        bit                prev_stall = 0;
        bit                prev_state = 0;
        logic signed [7:0] prev_data = '0;
        logic              prev_last = 0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall && prev_state) begin
                chk("hold_valid", longint'(bus.out_valid), 1);
                chk("hold_data", longint'(bus.out_data), longint'(prev_data));
                chk("hold_last", longint'(bus.out_last), longint'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", longint'(bus.out_data), 9999);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", longint'(bus.out_data), longint'(e.data));
                    chk("out_last", longint'(bus.out_last), longint'(e.last));
                    if (e.lat) chk("latency", longint'(cyc - e.acc_cyc), 2);
                end
            end
            if (done) done_cnt++;
            if (done || (bus.out_valid && bus.out_ready && bus.out_last))
                chk("done_on_last", longint'(done),
                    longint'(bus.out_valid && bus.out_ready && bus.out_last));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_state = state;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic start_layer(input logic [31:0] sc);
        int n;
        @(negedge clk);
        state     = 1'b1;
        scaler_in = 32'hDEAD_BEEF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) scaler_in = sc;
            #4;
            if (n == 1) chk("sat_clear_in_load", longint'(sat_flag), 0);
        end while (!bus.acc_ready && n < 20);
        chk("load_to_ready_cycles", longint'(n), 5);
    endtask

    task automatic send(input int d, input int ev, input bit last, input bit lat);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.acc_valid = 1'b1;
        bus.acc_data  = d;
        bus.acc_last  = last;
        n = 0;
        forever begin
            #4;
            if (bus.acc_ready) break;
            n++;
            if (n > 200) begin
                chk("acc_accept_timeout", longint'(n), 0);
                break;
            end
            @(negedge clk);
        end
        e.data    = ev[7:0];
        e.last    = last;
        e.acc_cyc = cyc;
        e.lat     = lat;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.acc_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        chk("done_count", longint'(done_cnt), longint'(target));
    endtask

    task automatic end_layer();
        @(negedge clk);
        state = 1'b0;
        bus.acc_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin : stim
        int base;
        int bad;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        bus.acc_last  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #4;
        chk("rst_acc_ready", longint'(bus.acc_ready), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_out_last", longint'(bus.out_last), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unity scale, including exact saturation bounds that must not clamp.
        base = done_cnt;
        start_layer(32'h0001_0000);
        send(100, 100, 0, 1);
        send(-5, -5, 0, 1);
        send(127, 127, 0, 1);
        send(-128, -128, 1, 1);
        wait_done(base + 1);
        @(negedge clk);
        #4;
        chk("s1_sat_flag", longint'(sat_flag), 0);
        chk("s1_ready_in_done", longint'(bus.acc_ready), 0);
        end_layer();

        // Half scale: rounding mode is visible on +/-1.5.
        base = done_cnt;
        start_layer(32'h0000_8000);
`ifdef SCALE_ROUND_EN
        send(3, 2, 0, 1);
        send(-3, -1, 1, 1);
`else
        send(3, 1, 0, 1);
        send(-3, -2, 1, 1);
`endif
        wait_done(base + 1);
        end_layer();

        // Saturation both ways; flag sticky until the layer ends.
        base = done_cnt;
        start_layer(32'h0001_0000);
        send(1000, 127, 0, 0);
        send(-1000, -128, 1, 0);
        wait_done(base + 1);
        repeat (3) @(negedge clk);
        #4;
        chk("s3_sat_sticky", longint'(sat_flag), 1);
        end_layer();
        #4;
        chk("s3_sat_cleared", longint'(sat_flag), 0);

        // Eight-word stream at 1.5x with downstream stall on cycles 3-7.
        base = done_cnt;
        start_layer(32'h0001_8000);
        fork
            begin
                send(10, 15, 0, 0);
                send(-20, -30, 0, 0);
                send(30, 45, 0, 0);
                send(-40, -60, 0, 0);
                send(50, 75, 0, 0);
                send(-60, -90, 0, 0);
                send(70, 105, 0, 0);
                send(-80, -120, 1, 0);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    bus.out_ready = !(i >= 3 && i <= 7);
                    if (i == 5) begin
                        #4;
                        chk("stall_acc_ready_low", longint'(bus.acc_ready), 0);
                        chk("stall_out_valid", longint'(bus.out_valid), 1);
                    end
                end
            end
        join
        wait_done(base + 1);
        end_layer();

        // Last on word 4; a fifth offered word must never be taken.
        base = done_cnt;
        start_layer(32'h0002_0000);
        send(1, 2, 0, 0);
        send(2, 4, 0, 0);
        send(3, 6, 0, 0);
        send(4, 8, 1, 0);
        bad = 0;
        @(negedge clk);
        bus.acc_valid = 1'b1;
        bus.acc_data  = 5;
        bus.acc_last  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #4;
            if (bus.acc_ready) bad++;
            @(negedge clk);
        end
        bus.acc_valid = 1'b0;
        chk("ready_after_last", longint'(bad), 0);
        chk("done_single_pulse", longint'(done_cnt), longint'(base + 1));
        end_layer();

        // Abort with two words in flight, then a clean restart.
        bus.out_ready = 1'b0;
        start_layer(32'h0001_0000);
        send(11, 11, 0, 0);
        send(22, 22, 0, 0);
        @(negedge clk);
        state = 1'b0;
        sb.delete();
        @(negedge clk);
        #4;
        chk("flush_out_valid", longint'(bus.out_valid), 0);
        chk("flush_acc_ready", longint'(bus.acc_ready), 0);
        bus.out_ready = 1'b1;
        base = done_cnt;
        start_layer(32'h0001_0000);
        send(33, 33, 1, 1);
        wait_done(base + 1);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", longint'(sb.size()), 0);
        end_layer();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scale_requant.md
SCALE_REQUANT -- requirements
Module: scale_requant

Interface
REQ-001 SHALL have parameter FEATURE_WIDTH, default 32: accumulator and scaler width.
REQ-002 SHALL have parameter OUT_WIDTH, default 8: requantized output width.
REQ-003 SHALL have parameter FRAC_BITS, default 16: fractional bits of the scaler, range 1..FEATURE_WIDTH-1.
REQ-004 SHALL have parameter SCALER_LAT, default 3: cycles from state rising until scaler_in is valid.
REQ-005 SHALL have the following ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- state  in  1  layer active; must be the same signal that drives the upstream scaler loader.
- scaler_in  in  FEATURE_WIDTH  signed fixed-point scale factor.
- acc_valid  in  1  accumulator word valid.
- acc_ready  out  1  accumulator word accepted when high together with acc_valid.
- acc_data  in  FEATURE_WIDTH  signed accumulator value.
- acc_last  in  1  marks the final word of the layer.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_WIDTH  signed requantized result.
- out_last  out  1  marks the final result.
- done  out  1  one-cycle pulse when the final result is accepted.
- sat_flag  out  1  sticky: some result in this layer saturated.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-007 IDLE->LOAD when state=1; LOAD counts SCALER_LAT+1 cycles, latches scaler_in into scale_reg on the last count, then moves to RUN.
REQ-008 In RUN, acc_ready SHALL be 1 only when no last word has been accepted and stage 1 can advance.
REQ-009 RUN->DRAIN on the acc_valid&acc_ready&acc_last handshake; DRAIN->DONE when out_last is accepted; done pulses in that cycle.
REQ-010 DONE SHALL hold until state=0, then return to IDLE; acc_ready stays 0 in DONE.
REQ-011 If state falls in any state other than IDLE, the block SHALL go to IDLE on the next edge, flush both pipeline stages (out_valid=0) and clear sat_flag.
REQ-012 SHALL use a two-stage pipeline:
- Stage 1: full-width product acc_data*scale_reg, signed, 2*FEATURE_WIDTH bits.
- Stage 2: arithmetic right shift by FRAC_BITS, rounding per REQ-019, then saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-013 Latency from accept to out_valid SHALL be 2 cycles with out_ready held high; throughput SHALL be 1 word/cycle.
REQ-014 A stage SHALL advance when it is empty or the next stage advances; with out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable and no word is lost or duplicated.
REQ-015 sat_flag SHALL set on any clamped result and clear on entering LOAD.
REQ-016 acc_last SHALL travel with its data through the pipeline.

Reset
REQ-017 On rst_n=0, the block SHALL enter IDLE and clear scale_reg, the LOAD counter and the valid bits of both stages.
REQ-018 On rst_n=0, all outputs SHALL be 0: acc_ready, out_valid, out_data, out_last, done, sat_flag.

Configuration
REQ-019 With SCALE_ROUND_EN defined, 2^(FRAC_BITS-1) SHALL be added before the shift (round half up); without it, the shift SHALL truncate toward negative infinity.

Structure
REQ-020 FSM state encoding and the saturation bound helpers SHALL live in shared package tnn_acc_pkg.
REQ-021 The saturation/round logic SHALL be a sub-module, requant_sat, which is combinational and parameterized by widths.

Verification
REQ-022 Benches SHALL use FRAC_BITS=16, OUT_WIDTH=8, SCALER_LAT=3. Directed scenarios:
- scaler 0x0001_0000, acc 100,-5 -> out 100,-5 two cycles after each accept; sat_flag=0.
- scaler 0x0000_8000, acc 3 -> out 2 with SCALE_ROUND_EN, 1 without.
- scaler 0x0001_0000, acc 1000 then -1000 -> out 127, -128; sat_flag=1 until next LOAD.
- Stream of 8 words, out_ready low for cycles 3-7 -> all 8 outputs in order, held stable while stalled, acc_ready low when full.
- acc_last on word 4 -> out_last on result 4, done pulses once, acc_ready stays 0 until state cycles 0->1.
- state dropped mid-stream with 2 words in flight -> next cycle out_valid=0, FSM IDLE; restart yields only new-layer results.
